// File: rtl/croc_xilinx_pkg.sv
// Shared FPGA-top constants for the 20 MHz soc_clk board wrapper.
package croc_xilinx_pkg;

  // Number of conditioned board inputs: four GPIO slide switches plus fetch-enable.
  localparam int unsigned BoardNumInputs = 5;

  // 20000 soc_clk cycles at 20 MHz gives a 1 ms debounce tick.
  localparam int unsigned BoardDebounceTickDiv = 20000;

  // An input must hold its new value for 10 ticks (about 10 ms) before it is accepted.
  localparam int unsigned BoardDebounceTicks = 10;

  // Channel index carrying the fetch-enable switch.
  localparam int unsigned FetchEnIdx = 4;

endpackage : croc_xilinx_pkg

// File: rtl/debounce_channel.sv
// One board input channel: synchroniser, tick-based debounce counter,
// debounced level register and registered edge pulses.
module debounce_channel #(
  parameter int unsigned SyncStages    = 2,
  parameter int unsigned DebounceTicks = 10,
  parameter logic        ResetBit      = 1'b0
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic raw_i,
  input  logic tick_i,
  input  logic bypass_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);

  localparam int unsigned CntW = $clog2(DebounceTicks + 1);
  localparam logic [CntW-1:0] CntLast = CntW'(DebounceTicks - 1);

  logic [SyncStages-1:0] sync_reg;
  logic                  sync_bit;
  logic [CntW-1:0]       cnt_reg, cnt_next;
  logic                  level_reg, level_next;
  logic                  prev_level_reg;

  // Shift raw_i through the synchroniser chain; the oldest stage is the clean sample.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync_reg <= {SyncStages{ResetBit}};
    end else begin
      sync_reg <= {sync_reg[SyncStages-2:0], raw_i};
    end
  end

  assign sync_bit = sync_reg[SyncStages-1];

  // Debounce decision: any agreement clears the count, a disagreement advances it
  // once per tick, and the last tick accepts the new value.
  always_comb begin
    level_next = level_reg;
    cnt_next   = cnt_reg;
    if (bypass_i) begin
      level_next = sync_bit;
      cnt_next   = '0;
    end else if (sync_bit == level_reg) begin
      cnt_next = '0;
    end else if (tick_i) begin
      if (cnt_reg == CntLast) begin
        level_next = sync_bit;
        cnt_next   = '0;
      end else begin
        cnt_next = cnt_reg + 1'b1;
      end
    end
  end

  // Counter, level and previous-level state.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_reg        <= '0;
      level_reg      <= ResetBit;
      prev_level_reg <= ResetBit;
    end else begin
      cnt_reg        <= cnt_next;
      level_reg      <= level_next;
      prev_level_reg <= level_reg;
    end
  end

  // Pulses come only from registers, so they last exactly one cycle and cannot overlap.
  assign level_o = level_reg;
  assign rise_o  = level_reg & ~prev_level_reg;
  assign fall_o  = ~level_reg & prev_level_reg;

endmodule : debounce_channel

// File: rtl/board_input_debounce.sv
// Conditions the asynchronous board switches before the SoC GPIO and
// fetch-enable logic: shared tick prescaler plus one filter per channel.
module board_input_debounce
  import croc_xilinx_pkg::*;
#(
  parameter int unsigned          NumInputs     = BoardNumInputs,
  parameter int unsigned          SyncStages    = 2,
  parameter int unsigned          TickDiv       = BoardDebounceTickDiv,
  parameter int unsigned          DebounceTicks = BoardDebounceTicks,
  parameter logic [NumInputs-1:0] ResetLevel    = '0
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [NumInputs-1:0] raw_i,
  input  logic                 bypass_i,
  output logic [NumInputs-1:0] level_o,
  output logic [NumInputs-1:0] rise_o,
  output logic [NumInputs-1:0] fall_o,
  output logic                 tick_o
);

  localparam int unsigned PreW = $clog2(TickDiv);
  localparam logic [PreW-1:0] PreLast = PreW'(TickDiv - 1);

  logic [PreW-1:0] presc_reg, presc_next;
  logic            tick;

  assign tick = (presc_reg == PreLast);

  // Prescaler wraps at TickDiv-1 so the tick is one cycle in every TickDiv.
  always_comb begin
    presc_next = presc_reg + 1'b1;
    if (tick) begin
      presc_next = '0;
    end
  end

  // Prescaler register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      presc_reg <= '0;
    end else begin
      presc_reg <= presc_next;
    end
  end

  assign tick_o = tick;

  // One independent filter per board input, all sharing the tick.
  for (genvar gi = 0; gi < NumInputs; gi++) begin : g_chan
    debounce_channel #(
      .SyncStages   (SyncStages),
      .DebounceTicks(DebounceTicks),
      .ResetBit     (ResetLevel[gi])
    ) u_chan (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .raw_i   (raw_i[gi]),
      .tick_i  (tick),
      .bypass_i(bypass_i),
      .level_o (level_o[gi]),
      .rise_o  (rise_o[gi]),
      .fall_o  (fall_o[gi])
    );
  end

endmodule : board_input_debounce

// File: tb/tb_board_input_debounce.sv
// Self-checking bench for board_input_debounce with TickDiv=4, DebounceTicks=3.
module tb_board_input_debounce;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] raw;
  logic       bypass;
  logic [4:0] level, rise, fall;
  logic       tick;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [4:0] raw;
    logic       byp;
    int         n;
    logic [4:0] lvl;
    logic [4:0] rise;
    logic [4:0] fall;
  } vec_t;

  vec_t vecs [7];

  board_input_debounce #(
    .NumInputs    (5),
    .SyncStages   (2),
    .TickDiv      (4),
    .DebounceTicks(3),
    .ResetLevel   (5'b00000)
  ) dut (
    .clk_i   (clk),
    .rst_i   (rst),
    .raw_i   (raw),
    .bypass_i(bypass),
    .level_o (level),
    .rise_o  (rise),
    .fall_o  (fall),
    .tick_o  (tick)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end else begin
      $display("ok   %s: %0h", name, act);
    end
  endtask

  // Advance one clock edge and land on the following falling edge.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Wait for level_o to move away from its current value, then check that the
  // change is complete in one cycle, lands in the 11..15 window and pulses once.
  task automatic wait_change(input string name, input logic [4:0] exp_lvl,
                             input logic [4:0] exp_rise, input logic [4:0] exp_fall);
    logic [4:0] start;
    int         k;
    bit         seen;
    start = level;
    seen  = 1'b0;
    k     = 0;
    for (int i = 1; i <= 40; i++) begin
      step();
      if (level != start) begin
        k    = i;
        seen = 1'b1;
        break;
      end
    end
    chk({name, "_seen"}, 32'(seen), 32'd1);
    chk({name, "_lat_ok"}, 32'(k >= 11 && k <= 15), 32'd1);
    chk({name, "_level"}, 32'(level), 32'(exp_lvl));
    chk({name, "_rise"}, 32'(rise), 32'(exp_rise));
    chk({name, "_fall"}, 32'(fall), 32'(exp_fall));
    step();
    chk({name, "_pulse_end"}, 32'({rise, fall}), 32'd0);
    chk({name, "_level_hold"}, 32'(level), 32'(exp_lvl));
  endtask

  // Rise and fall on the same channel must never coincide.
  always @(negedge clk) begin
    checks++;
    if ((rise & fall) != 5'b0) begin
      errors++;
      $display("FAIL overlap: got rise %0h fall %0h expected disjoint", rise, fall);
    end
  end

  initial begin
    bit quiet;

    vecs[0] = '{raw: 5'b00000, byp: 1'b1, n: 3, lvl: 5'b00000, rise: 5'b00000, fall: 5'b00100};
    vecs[1] = '{raw: 5'b01010, byp: 1'b1, n: 3, lvl: 5'b01010, rise: 5'b01010, fall: 5'b00000};
    vecs[2] = '{raw: 5'b01010, byp: 1'b1, n: 1, lvl: 5'b01010, rise: 5'b00000, fall: 5'b00000};
    vecs[3] = '{raw: 5'b10001, byp: 1'b1, n: 3, lvl: 5'b10001, rise: 5'b10001, fall: 5'b01010};
    vecs[4] = '{raw: 5'b10001, byp: 1'b1, n: 1, lvl: 5'b10001, rise: 5'b00000, fall: 5'b00000};
    vecs[5] = '{raw: 5'b00000, byp: 1'b1, n: 3, lvl: 5'b00000, rise: 5'b00000, fall: 5'b10001};
    vecs[6] = '{raw: 5'b00000, byp: 1'b1, n: 2, lvl: 5'b00000, rise: 5'b00000, fall: 5'b00000};

    // Reset with all inputs high.
    rst    = 1'b1;
    raw    = 5'b11111;
    bypass = 1'b0;
    for (int i = 0; i < 3; i++) step();
    chk("reset_level", 32'(level), 32'd0);
    chk("reset_pulses", 32'({rise, fall}), 32'd0);
    chk("reset_tick", 32'(tick), 32'd0);

    // Tick phase: first tick on post-reset cycle 3, then every 4 cycles.
    rst = 1'b0;
    raw = 5'b00000;
    #1;
    chk("tick_c0", 32'(tick), 32'd0);
    for (int j = 1; j < 12; j++) begin
      step();
      chk($sformatf("tick_c%0d", j), 32'(tick), 32'((j % 4) == 3));
    end

    // Clean step on channel 0.
    raw = 5'b00001;
    wait_change("clean_step", 5'b00001, 5'b00001, 5'b00000);

    // Bounce on channel 1: toggle every 3 cycles for 60 cycles.
    quiet = 1'b1;
    for (int c = 0; c < 60; c++) begin
      if ((c % 3) == 0) raw[1] = ~raw[1];
      step();
      if (level[1] || rise[1] || fall[1]) quiet = 1'b0;
    end
    chk("bounce_quiet", 32'(quiet), 32'd1);
    raw[1] = 1'b1;
    wait_change("bounce_settle", 5'b00011, 5'b00010, 5'b00000);

    // Clear state for the simultaneous test.
    raw = 5'b00000;
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("reset2_level", 32'(level), 32'd0);

    raw = 5'b10101;
    wait_change("simul_rise", 5'b10101, 5'b10101, 5'b00000);
    raw = 5'b00000;
    wait_change("simul_fall", 5'b00000, 5'b00000, 5'b10101);

    // Reset part-way through a debounce on channel 2.
    raw   = 5'b00100;
    quiet = 1'b1;
    for (int c = 0; c < 8; c++) begin
      step();
      if (level[2] || rise[2]) quiet = 1'b0;
    end
    chk("midrst_no_early", 32'(quiet), 32'd1);
    rst = 1'b1;
    step();
    chk("midrst_level", 32'(level), 32'd0);
    chk("midrst_pulses", 32'({rise, fall}), 32'd0);
    rst = 1'b0;
    wait_change("midrst_restart", 5'b00100, 5'b00100, 5'b00000);

    // Bypass vectors: level follows the synchroniser one stage later.
    for (int v = 0; v < 7; v++) begin
      raw    = vecs[v].raw;
      bypass = vecs[v].byp;
      for (int c = 0; c < vecs[v].n; c++) step();
      chk($sformatf("vec%0d_level", v), 32'(level), 32'(vecs[v].lvl));
      chk($sformatf("vec%0d_rise", v), 32'(rise), 32'(vecs[v].rise));
      chk($sformatf("vec%0d_fall", v), 32'(fall), 32'(vecs[v].fall));
    end

    // Bypass: single-cycle pulse on channel 3.
    raw = 5'b01000;
    step();
    raw = 5'b00000;
    chk("byp_e1", 32'({level, rise, fall}), 32'd0);
    step();
    chk("byp_e2", 32'({level, rise, fall}), 32'd0);
    step();
    chk("byp_e3_level", 32'(level), 32'(5'b01000));
    chk("byp_e3_rise", 32'(rise), 32'(5'b01000));
    chk("byp_e3_fall", 32'(fall), 32'd0);
    step();
    chk("byp_e4_level", 32'(level), 32'd0);
    chk("byp_e4_rise", 32'(rise), 32'd0);
    chk("byp_e4_fall", 32'(fall), 32'(5'b01000));
    step();
    chk("byp_e5", 32'({level, rise, fall}), 32'd0);

    // Leaving bypass with settled inputs produces no pulses.
    bypass = 1'b0;
    quiet  = 1'b1;
    for (int c = 0; c < 6; c++) begin
      step();
      if (level != 5'b0 || rise != 5'b0 || fall != 5'b0) quiet = 1'b0;
    end
    chk("byp_exit_quiet", 32'(quiet), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_board_input_debounce
